// File: rtl/conv_window_accumulator.sv
// Window accumulator after the pixel x weight multiplier: sums K*K signed products,
// then shifts, applies ReLU, saturates to X bits and offers the pixel over valid/ready.
module conv_window_accumulator #(
  parameter int X     = 4,
  parameter int K     = 3,
  parameter int ACC_W = 2*X+4,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Start,
  input  logic                    prod_valid,
  input  logic signed [2*X-1:0]   prod_data,
  output logic                    prod_ready,
  output logic                    pix_valid,
  output logic [X-1:0]            pix_data,
  input  logic                    pix_ready,
  output logic signed [ACC_W-1:0] sum_raw,
  output logic [3:0]              tap_cnt,
  output logic [15:0]             pix_cnt
);

  localparam int TAPS = K*K;
  localparam logic [3:0] LAST_TAP = 4'(TAPS-1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << X) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_raw_q, sum_raw_d;
  logic [X-1:0]            pix_data_q, pix_data_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    prod_ready_q, prod_ready_d;
  logic [3:0]              tap_cnt_q, tap_cnt_d;
  logic [15:0]             pix_cnt_q, pix_cnt_d;

  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shifted_s;

  // Negative values clamp to zero, values above the X-bit range clamp to all ones.
  function automatic logic [X-1:0] relu_sat(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1]) begin
      return {X{1'b0}};
    end else if (v > PIX_MAX) begin
      return {X{1'b1}};
    end else begin
      return v[X-1:0];
    end
  endfunction

  // Window sum including the product on the bus, and its shifted form.
  always_comb begin
    prod_ext_s = {{(ACC_W-2*X){prod_data[2*X-1]}}, prod_data};
    sum_s      = acc_q + prod_ext_s;
    shifted_s  = sum_s >>> SHIFT;
  end

  // Next-state and datapath updates; Start low overrides any handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_raw_d   = sum_raw_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    tap_cnt_d   = tap_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    if (!Start) begin
      state_d     = IDLE;
      acc_d       = '0;
      tap_cnt_d   = 4'd0;
      pix_valid_d = 1'b0;
      pix_cnt_d   = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACC;
        end
        ACC: begin
          if (prod_valid && prod_ready_q) begin
            if (tap_cnt_q == LAST_TAP) begin
              sum_raw_d   = sum_s;
              pix_data_d  = relu_sat(shifted_s);
              pix_valid_d = 1'b1;
              acc_d       = '0;
              tap_cnt_d   = 4'd0;
              state_d     = OUT;
            end else begin
              acc_d     = sum_s;
              tap_cnt_d = tap_cnt_q + 4'd1;
            end
          end else begin
            state_d = ACC;
          end
        end
        OUT: begin
          if (pix_ready) begin
            pix_valid_d = 1'b0;
            pix_cnt_d   = pix_cnt_q + 16'd1;
            state_d     = ACC;
          end else begin
            state_d = OUT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    prod_ready_d = (state_d == ACC);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      sum_raw_q    <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      prod_ready_q <= 1'b0;
      tap_cnt_q    <= 4'd0;
      pix_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      sum_raw_q    <= sum_raw_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      prod_ready_q <= prod_ready_d;
      tap_cnt_q    <= tap_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign sum_raw    = sum_raw_q;
  assign tap_cnt    = tap_cnt_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Bench for conv_window_accumulator: directed windows plus random traffic checked
// against a window-level reference model (SHIFT=0 and SHIFT=6 instances).
module tb_conv_window_accumulator;
  localparam int X     = 4;
  localparam int K     = 3;
  localparam int TAPS  = K*K;
  localparam int ACC_W = 2*X+4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic prod_valid = 1'b0;
  logic pix_ready = 1'b0;
  logic [2*X-1:0] prod_data = '0;

  logic             prod_ready, pix_valid, prod_ready6, pix_valid6;
  logic [X-1:0]     pix_data, pix_data6;
  logic [ACC_W-1:0] sum_raw, sum_raw6;
  logic [3:0]       tap_cnt, tap_cnt6;
  logic [15:0]      pix_cnt, pix_cnt6;

  conv_window_accumulator #(.X(X), .K(K), .ACC_W(ACC_W), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .Start(start),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .sum_raw(sum_raw), .tap_cnt(tap_cnt), .pix_cnt(pix_cnt)
  );

  conv_window_accumulator #(.X(X), .K(K), .ACC_W(ACC_W), .SHIFT(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .Start(start),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready6),
    .pix_valid(pix_valid6), .pix_data(pix_data6), .pix_ready(pix_ready),
    .sum_raw(sum_raw6), .tap_cnt(tap_cnt6), .pix_cnt(pix_cnt6)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: accepted products of the open window, pending pixel, counters.
  bit     running = 1'b0;
  bit     pending = 1'b0;
  longint window[$];
  longint exp_sum = 0;
  int     pcnt = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint relu_sat(input longint v, input int sh);
    longint s;
    s = v >>> sh;
    if (s < 0) return 0;
    if (s > (2**X - 1)) return 2**X - 1;
    return s;
  endfunction

  task automatic model_reset();
    running = 1'b0;
    pending = 1'b0;
    window.delete();
    exp_sum = 0;
    pcnt = 0;
  endtask

  task automatic model_update();
    longint s;
    if (!start) begin
      running = 1'b0;
      pending = 1'b0;
      window.delete();
      pcnt = 0;
    end else if (!running) begin
      running = 1'b1;
    end else if (pending) begin
      if (pix_ready) begin
        pending = 1'b0;
        pcnt = (pcnt + 1) % 65536;
      end
    end else if (prod_valid) begin
      window.push_back(longint'($signed(prod_data)));
      if (window.size() == TAPS) begin
        s = 0;
        foreach (window[i]) s += window[i];
        exp_sum = s;
        pending = 1'b1;
        window.delete();
      end
    end
  endtask

  task automatic compare_all();
    check_eq("prod_ready", longint'(prod_ready), longint'(running && !pending));
    check_eq("pix_valid",  longint'(pix_valid),  longint'(pending));
    check_eq("tap_cnt",    longint'(tap_cnt),    longint'(window.size()));
    check_eq("pix_cnt",    longint'(pix_cnt),    longint'(pcnt));
    check_eq("sum_raw",    longint'($signed(sum_raw)), exp_sum);
    check_eq("pix_data",   longint'(pix_data),   relu_sat(exp_sum, 0));
    check_eq("pix_data_sh6", longint'(pix_data6), relu_sat(exp_sum, 6));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic send(input int d);
    prod_valid = 1'b1;
    prod_data  = (2*X)'(d);
    step();
  endtask

  initial begin
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    pix_ready = 1'b1;
    step();

    // Basic window of +1s, then the output handshake.
    for (int i = 0; i < TAPS; i++) send(1);
    prod_valid = 1'b0;
    step();

    // Saturation high, then ReLU of a negative sum.
    for (int i = 0; i < TAPS; i++) send(105);
    prod_valid = 1'b0;
    step();
    for (int i = 0; i < TAPS; i++) send(-120);
    prod_valid = 1'b0;
    step();

    // Bubbles between products 1..9, then held backpressure with junk beats.
    pix_ready = 1'b0;
    for (int i = 1; i <= TAPS; i++) begin
      send(i);
      prod_valid = 1'b0;
      prod_data  = 8'h7f;
      step();
    end
    for (int i = 0; i < 5; i++) send(-7);
    pix_ready = 1'b1;
    prod_valid = 1'b0;
    step();

    // Abort a partial window, then a clean window left waiting in OUT.
    for (int i = 0; i < 4; i++) send(3);
    prod_valid = 1'b0;
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    pix_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) send(1);
    prod_valid = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      start      = ($urandom_range(0, 59) != 0);
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_data  = (2*X)'($urandom);
      pix_ready  = ($urandom_range(0, 2) != 0);
      step();
    end

    // Mid-cycle async reset with Start high: outputs clear without a clock edge.
    start = 1'b1;
    prod_valid = 1'b1;
    pix_ready = 1'b0;
    for (int i = 0; i < TAPS + 2; i++) send(100);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    prod_valid = 1'b0;
    step();
    for (int i = 0; i < TAPS; i++) send(2);
    pix_ready = 1'b1;
    prod_valid = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_accumulator.md
Name: conv_window_accumulator

Overview:
- Sequential stage directly downstream of the signed pixel×weight multiplier in the two-layer CNN datapath.
- Consumes a stream of signed 2X-bit products and accumulates K*K of them per output pixel.
- Applies an arithmetic right shift, ReLU and unsigned saturation to X bits.
- Emits one feature-map pixel per window over a valid/ready handshake. Its output feeds the second layer's image input.

Parameters:
- X, 4: pixel/weight width; product width is 2X.
- K, 3: kernel side; taps per window TAPS = K*K.
- ACC_W, 2*X+4: accumulator width; must be at least 2X+ceil(log2(TAPS)).
- SHIFT, 0: arithmetic right shift applied to the window sum before ReLU/saturation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  run enable; low forces IDLE and clears window state (same meaning as multiplier Start)
- prod_valid  in  1  product beat valid
- prod_data  in  2X signed  multiplier product
- prod_ready  out  1  stage accepts a product this cycle
- pix_valid  out  1  output pixel valid
- pix_data  out  X unsigned  ReLU/saturated feature pixel
- pix_ready  in  1  downstream accepts pixel
- sum_raw  out  ACC_W signed  full window sum of the last completed window (debug)
- tap_cnt  out  4  products accepted in current window, 0..TAPS-1
- pix_cnt  out  16  pixels emitted since reset/Start low, wraps 65535->0

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all outputs 0 (prod_ready, pix_valid, pix_data, sum_raw, tap_cnt, pix_cnt); accumulator 0.
- States: IDLE, ACC, OUT.
- IDLE: prod_ready=0. Moves to ACC on the next clk when Start=1.
- ACC:
  - prod_ready=1.
  - Product accepted on the cycle with prod_valid&prod_ready.
  - acc += sign-extend(prod_data) to ACC_W; tap_cnt++.
  - Bubbles (prod_valid=0) leave all state unchanged.
- On the TAPS-th accepted product (tap_cnt==TAPS-1):
  - Full sum S = acc+prod is computed combinationally.
  - Next edge: sum_raw=S; pix_data=sat(relu(S>>>SHIFT)); pix_valid=1; acc=0; tap_cnt=0; state=OUT.
  - Latency is one cycle from the final product handshake to pix_valid.
- Saturation/ReLU: value < 0 -> 0; value > 2^X-1 -> 2^X-1; otherwise the low X bits.
- OUT:
  - prod_ready=0.
  - pix_valid, pix_data and sum_raw are held stable until pix_ready=1.
  - On that edge: pix_valid=0; pix_cnt++ (wraps); state=ACC.
  - Peak throughput is TAPS+1 cycles per pixel.
- Start=0 in any state: next edge goes to IDLE; acc, tap_cnt, pix_valid and pix_cnt are cleared; a pending unaccepted pixel is discarded. sum_raw and pix_data keep their last values.
- Start=0 takes priority over any simultaneous handshake.
- No overflow is possible when ACC_W meets the minimum width; the accumulator is not saturated internally.
- prod_data is ignored whenever prod_ready=0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with Start=1 -> outputs go to 0 immediately (no clock edge), state IDLE; release -> prod_ready=1 one cycle after Start is seen high.
- Basic window: nine products of +1, back-to-back, pix_ready=1 -> pix_valid one cycle after the 9th beat, pix_data=9, sum_raw=9, pix_cnt=1, tap_cnt=0.
- Saturation/ReLU: nine products of +105 -> sum_raw=945, pix_data=15; nine products of -120 -> sum_raw=-1080, pix_data=0. With SHIFT=6 and nine products of +105 -> 945>>>6=14, pix_data=14.
- Backpressure and bubbles:
  - Products 1..9 with prod_valid toggling 1/0 -> sum_raw=45, pix_data=15.
  - Hold pix_ready=0 for 5 cycles -> pix_valid stays 1, pix_data stable, prod_ready=0 and extra prod_valid beats are ignored.
  - Then pix_ready=1 -> one handshake; next window starts with acc=0.
- Start abort: accept 4 products of +3, drop Start for 1 cycle -> IDLE, tap_cnt=0, pix_cnt=0, no pix_valid. Re-raise Start, send nine products of +1 -> pix_data=9 (no residue from the aborted window).
- Start drop while in OUT with pix_ready=0 -> pix_valid falls next edge, pix_cnt unchanged at 0.
